// File: rtl/rgb_color_sweep.sv
// Six-sector HSV hue-wheel sweeper driving the RGB PWM duty words, with brightness scaling.
// Optional breathing envelope on the brightness is enabled by defining RGB_SWEEP_BREATHE_EN.
`timescale 1ns/1ps

module rgb_color_sweep #(
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] step_div,
  input  logic [DUTY_W-1:0]     brightness,
  input  logic                  hue_load,
  input  logic [DUTY_W+2:0]     hue_value,
  output logic [DUTY_W-1:0]     red_duty,
  output logic [DUTY_W-1:0]     green_duty,
  output logic [DUTY_W-1:0]     blue_duty,
  output logic [2:0]            sector,
  output logic                  wrap
);

  localparam logic [DUTY_W-1:0] M       = '1;
  localparam logic [2:0]        SEC_MAX = 3'd5;

  logic [PRESCALE_W-1:0] pcnt;
  logic [2:0]            sec;
  logic [DUTY_W-1:0]     frac;
  logic                  tick;
  logic [2:0]            load_sec;
  logic [DUTY_W-1:0]     map_r, map_g, map_b;
  logic [DUTY_W-1:0]     raw_r, raw_g, raw_b;
  logic [DUTY_W-1:0]     scale_bright;
  logic [DUTY_W:0]       bright_inc;
  logic [2*DUTY_W:0]     prod_r, prod_g, prod_b;
  logic                  scale_unused;

  // >= rather than == so a step_div lowered mid-count ticks on the next cycle
  assign tick     = enable && (pcnt >= step_div);
  assign load_sec = hue_value[DUTY_W+2:DUTY_W];
  assign sector   = sec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (hue_load) begin
      pcnt <= '0;
    end else if (enable) begin
      if (pcnt >= step_div) pcnt <= '0;
      else                  pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec  <= '0;
      frac <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (hue_load) begin
        sec  <= (load_sec > SEC_MAX) ? 3'd0 : load_sec;
        frac <= hue_value[DUTY_W-1:0];
      end else if (tick) begin
        if (frac == M) begin
          frac <= '0;
          if (sec >= SEC_MAX) begin
            sec  <= '0;
            wrap <= 1'b1;
          end else begin
            sec <= sec + 3'd1;
          end
        end else begin
          frac <= frac + DUTY_W'(1);
        end
      end
    end
  end

  always_comb begin
    map_r = '0;
    map_g = '0;
    map_b = '0;
    case (sec)
      3'd0: begin map_r = M;        map_g = frac;     map_b = '0;       end
      3'd1: begin map_r = M - frac; map_g = M;        map_b = '0;       end
      3'd2: begin map_r = '0;       map_g = M;        map_b = frac;     end
      3'd3: begin map_r = '0;       map_g = M - frac; map_b = M;        end
      3'd4: begin map_r = frac;     map_g = '0;       map_b = M;        end
      3'd5: begin map_r = M;        map_g = '0;       map_b = M - frac; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_r <= '0;
      raw_g <= '0;
      raw_b <= '0;
    end else begin
      raw_r <= map_r;
      raw_g <= map_g;
      raw_b <= map_b;
    end
  end

`ifdef RGB_SWEEP_BREATHE_EN
  logic [DUTY_W-1:0] env;
  logic [DUTY_W-1:0] eff_bright;
  logic              env_down;
  logic [2*DUTY_W:0] prod_env;
  logic              env_unused;

  assign prod_env     = (2*DUTY_W+1)'(brightness) * (2*DUTY_W+1)'({1'b0, env} + (DUTY_W+1)'(1));
  assign env_unused   = ^{prod_env[2*DUTY_W], prod_env[DUTY_W-1:0]};
  assign scale_bright = eff_bright;

  // Triangle envelope: ramps up to M, back down to 0, one step per hue tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env        <= '0;
      env_down   <= 1'b0;
      eff_bright <= '0;
    end else begin
      eff_bright <= prod_env[2*DUTY_W-1:DUTY_W];
      if (tick) begin
        if (!env_down) begin
          if (env == M) begin
            env_down <= 1'b1;
            env      <= env - DUTY_W'(1);
          end else begin
            env <= env + DUTY_W'(1);
          end
        end else if (env == '0) begin
          env_down <= 1'b0;
          env      <= env + DUTY_W'(1);
        end else begin
          env <= env - DUTY_W'(1);
        end
      end
    end
  end
`else
  assign scale_bright = brightness;
`endif

  // Scaling by brightness+1 makes brightness=M an exact pass-through
  assign bright_inc   = {1'b0, scale_bright} + (DUTY_W+1)'(1);
  assign prod_r       = (2*DUTY_W+1)'(raw_r) * (2*DUTY_W+1)'(bright_inc);
  assign prod_g       = (2*DUTY_W+1)'(raw_g) * (2*DUTY_W+1)'(bright_inc);
  assign prod_b       = (2*DUTY_W+1)'(raw_b) * (2*DUTY_W+1)'(bright_inc);
  assign scale_unused = ^{prod_r[2*DUTY_W], prod_r[DUTY_W-1:0],
                          prod_g[2*DUTY_W], prod_g[DUTY_W-1:0],
                          prod_b[2*DUTY_W], prod_b[DUTY_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_duty   <= '0;
      green_duty <= '0;
      blue_duty  <= '0;
    end else begin
      red_duty   <= prod_r[2*DUTY_W-1:DUTY_W];
      green_duty <= prod_g[2*DUTY_W-1:DUTY_W];
      blue_duty  <= prod_b[2*DUTY_W-1:DUTY_W];
    end
  end

endmodule

// File: tb/tb_rgb_color_sweep.sv
// Self-checking bench for rgb_color_sweep: hue/brightness vector table through a scoreboard,
// plus hand-written sequences for reset, prescaler, wrap and full-wheel timing.
`timescale 1ns/1ps

module tb_rgb_color_sweep;

  localparam int DUTY_W     = 8;
  localparam int PRESCALE_W = 24;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  enable = 1'b0;
  logic [PRESCALE_W-1:0] step_div = '0;
  logic [DUTY_W-1:0]     brightness = '0;
  logic                  hue_load = 1'b0;
  logic [DUTY_W+2:0]     hue_value = '0;
  logic [DUTY_W-1:0]     red_duty, green_duty, blue_duty;
  logic [2:0]            sector;
  logic                  wrap;

  typedef struct {
    logic [10:0] hue;
    logic [7:0]  bright;
    logic [7:0]  r, g, b;
    logic [2:0]  sec;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] r, g, b;
    logic [2:0] sec;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   wrap_count = 0;

  rgb_color_sweep #(.DUTY_W(DUTY_W), .PRESCALE_W(PRESCALE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .step_div   (step_div),
    .brightness (brightness),
    .hue_load   (hue_load),
    .hue_value  (hue_value),
    .red_duty   (red_duty),
    .green_duty (green_duty),
    .blue_duty  (blue_duty),
    .sector     (sector),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap) wrap_count++;

  task automatic checkValue(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkValue("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      checkValue({e.name, ".red"},    red_duty,   e.r);
      checkValue({e.name, ".green"},  green_duty, e.g);
      checkValue({e.name, ".blue"},   blue_duty,  e.b);
      checkValue({e.name, ".sector"}, sector,     e.sec);
    end
  endtask

  task automatic pushExpected(input string name, input int r, input int g, input int b, input int s);
    exp_t e;
    e.name = name;
    e.r    = 8'(r);
    e.g    = 8'(g);
    e.b    = 8'(b);
    e.sec  = 3'(s);
    sb_q.push_back(e);
  endtask

  // Load a hue with the sweep frozen and compare the colour three edges later
  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge clk);
    hue_load   = 1'b1;
    hue_value  = v.hue;
    brightness = v.bright;
    pushExpected(name, v.r, v.g, v.b, v.sec);
    @(negedge clk);
    hue_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic loadHue(input logic [10:0] h);
    @(negedge clk);
    hue_load  = 1'b1;
    hue_value = h;
    enable    = 1'b0;
    @(negedge clk);
    hue_load = 1'b0;
  endtask

  initial begin
    int cycles;

    vecs[0]  = '{11'h000, 8'd255, 8'd255, 8'd0,   8'd0,   3'd0};
    vecs[1]  = '{11'h040, 8'd255, 8'd255, 8'd64,  8'd0,   3'd0};
    vecs[2]  = '{11'h140, 8'd255, 8'd191, 8'd255, 8'd0,   3'd1};
    vecs[3]  = '{11'h280, 8'd127, 8'd0,   8'd127, 8'd64,  3'd2};
    vecs[4]  = '{11'h3C0, 8'd255, 8'd0,   8'd63,  8'd255, 3'd3};
    vecs[5]  = '{11'h410, 8'd255, 8'd16,  8'd0,   8'd255, 3'd4};
    vecs[6]  = '{11'h5FF, 8'd255, 8'd255, 8'd0,   8'd0,   3'd5};
    vecs[7]  = '{11'h620, 8'd255, 8'd255, 8'd32,  8'd0,   3'd0};
    vecs[8]  = '{11'h7FF, 8'd255, 8'd255, 8'd255, 8'd0,   3'd0};
    vecs[9]  = '{11'h1FF, 8'd0,   8'd0,   8'd0,   8'd0,   3'd1};
    vecs[10] = '{11'h2FF, 8'd128, 8'd0,   8'd128, 8'd128, 3'd2};
    vecs[11] = '{11'h4AA, 8'd200, 8'd133, 8'd0,   8'd200, 3'd4};

    // Reset state, then idle release with full brightness
    #2 reset = 1'b1;
    #1;
    checkValue("reset.red",    red_duty,   0);
    checkValue("reset.green",  green_duty, 0);
    checkValue("reset.blue",   blue_duty,  0);
    checkValue("reset.sector", sector,     0);
    checkValue("reset.wrap",   wrap,       0);
    repeat (2) @(negedge clk);
    brightness = 8'd255;
    reset      = 1'b0;
    pushExpected("release", 255, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput();
    wrap_count = 0;
    pushExpected("idle1000", 255, 0, 0, 0);
    repeat (1000) @(negedge clk);
    checkOutput();
    checkValue("idle1000.wrap_count", wrap_count, 0);

    // Mapping and scaling table
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Brightness reaches the outputs one cycle after it changes
    brightness = 8'd255;
    loadHue(11'h000);
    repeat (2) @(negedge clk);
    checkValue("bright_lat.before", red_duty, 255);
    brightness = 8'd0;
    @(negedge clk);
    checkValue("bright_lat.after", red_duty, 0);
    brightness = 8'd255;

    // Prescaler: tick every 4 cycles
    step_div = 24'd3;
    loadHue(11'h000);
    enable = 1'b1;
    repeat (17) @(negedge clk);
    checkValue("presc.green_17", green_duty, 3);
    @(negedge clk);
    checkValue("presc.green_18", green_duty, 4);
    checkValue("presc.red_18",   red_duty,   255);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("freeze.green",  green_duty, 4);
    checkValue("freeze.sector", sector,     0);

    // Lowering step_div mid-count ticks on the very next edge
    step_div = 24'd10;
    loadHue(11'h000);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    step_div = 24'd2;
    repeat (2) @(negedge clk);
    checkValue("stepdiv_drop.green_before", green_duty, 0);
    @(negedge clk);
    checkValue("stepdiv_drop.green_after", green_duty, 1);
    enable = 1'b0;

    // Wrap from the last hue of sector 5
    step_div = 24'd0;
    loadHue(11'h5FF);
    checkValue("wrap.load_sector", sector, 5);
    checkValue("wrap.load_nowrap", wrap,   0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    checkValue("wrap.pulse",  wrap,   1);
    checkValue("wrap.sector", sector, 0);
    @(negedge clk);
    checkValue("wrap.one_cycle", wrap, 0);
    pushExpected("wrap.colour", 255, 0, 0, 0);
    @(negedge clk);
    checkOutput();

    // Full wheel with step_div=0 takes 6*256 ticks
    loadHue(11'h000);
    enable = 1'b1;
    cycles = 0;
    while (cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (wrap) break;
    end
    enable = 1'b0;
    checkValue("wheel.cycles", cycles, 1536);
    @(negedge clk);
    checkValue("wheel.wrap_one_cycle", wrap, 0);

    // Asynchronous reset in the middle of a sweep
    loadHue(11'h100);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkValue("midreset.red",    red_duty,   0);
    checkValue("midreset.green",  green_duty, 0);
    checkValue("midreset.blue",   blue_duty,  0);
    checkValue("midreset.wrap",   wrap,       0);
    checkValue("midreset.sector", sector,     0);
    @(negedge clk);
    reset = 1'b0;
    pushExpected("restart", 255, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput();
    @(negedge clk);
    checkValue("restart.green_next", green_duty, 1);
    enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rgb_color_sweep.md
# rgb_color_sweep

Hue-wheel colour generator that produces the three PWM duty words for the RGB LED driver. It walks a six-sector HSV hue wheel at a programmable rate, scales the result by a global brightness, and presents registered `red_duty`/`green_duty`/`blue_duty` words that connect directly to the per-channel PWM stage. It sits between the board control logic (switches or registers) and the RGB LED PWM driver.

## Interface
- `DUTY_W`, 8: width of each duty word and of the hue fraction; `M` = 2^DUTY_W − 1.
- `PRESCALE_W`, 24: width of the step divider.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  hue advances while high; the prescaler holds while low.
- `step_div`  in  PRESCALE_W  hue step period is `step_div`+1 clocks.
- `brightness`  in  DUTY_W  global scale, where `M` means full scale.
- `hue_load`  in  1  one-cycle strobe that loads `hue_value`.
- `hue_value`  in  3+DUTY_W  bits [DUTY_W+2:DUTY_W] give the sector and the low bits give the fraction.
- `red_duty`, `green_duty`, `blue_duty`  out  DUTY_W each  registered duty words.
- `sector`  out  3  current hue sector, 0..5.
- `wrap`  out  1  one-cycle pulse when the hue wraps from sector 5 to sector 0.

## Operation
- State:
  - prescaler `pcnt` (PRESCALE_W bits);
  - hue = {`sec`, `frac`};
  - stage-1 registers `raw_r`/`raw_g`/`raw_b`;
  - stage-2 output registers.
- Prescaler, when `enable`=1:
  - If `pcnt >= step_div`, `tick`=1 and `pcnt` is set to 0.
  - Otherwise `pcnt` increments.
  - Using `>=` means a `step_div` reduced mid-count still ticks on the next cycle.
- On `tick`, `frac` increments. When `frac`==`M`, `frac` is set to 0 and `sec` increments. When `sec`==5, `sec` is set to 0 and `wrap` pulses.
- `hue_load` has priority over `tick`:
  - `sec` and `frac` take the values from `hue_value`.
  - A sector value of 6 or 7 loads as 0.
  - `pcnt` is cleared.
  - `wrap` is not asserted.
- Mapping, with f = `frac` (R, G, B):
  - sector 0: M, f, 0
  - sector 1: M−f, M, 0
  - sector 2: 0, M, f
  - sector 3: 0, M−f, M
  - sector 4: f, 0, M
  - sector 5: M, 0, M−f
- Scaling: out = (raw × (brightness+1)) >> DUTY_W.
  - The product width is 2·DUTY_W+1.
  - There is no rounding.
  - `brightness`=M gives out=raw exactly; `brightness`=0 gives 0 for every raw value.
- `sector` is the live `sec` register.

## Timing
- Reset values: `pcnt`, `sec`, `frac`, the raw registers, all three duty outputs, and `wrap` are 0.
- After reset releases, outputs reach the sector-0 colour (M, 0, 0)·scale two cycles later.
- Latency from a hue register update to the stage-1 raw registers is 1 cycle. The duty outputs update 1 cycle after that.
- Latency from a `brightness` change to the outputs is 1 cycle, because brightness is used only in stage 2.
- `wrap` is registered and asserts in the same cycle that `sec` becomes 0.
- Asserting `reset` mid-sweep forces all outputs to 0 immediately, without waiting for a clock edge.
- With `step_div`=0 and `enable`=1, the hue advances every cycle. A full wheel takes 6·2^DUTY_W ticks.
- When `enable` falls, the hue freezes and the outputs settle to the frozen colour within 2 cycles.

## Configuration
- `RGB_SWEEP_BREATHE_EN` defined:
  - Adds an envelope counter `env` (DUTY_W bits) and a direction bit, both reset to 0 / up.
  - On each `tick`, `env` steps by 1, reversing direction at `M` and at 0.
  - The effective brightness is (brightness × (env+1)) >> DUTY_W. It is registered, which adds 1 cycle to brightness latency only.
  - `hue_load` does not affect `env`.
- Not defined: there is no envelope logic and `brightness` is used directly, as described above.

## Test plan
- Reset, then release with `enable`=0 and `brightness`=255 → within 2 cycles R=255, G=0, B=0; `sector`=0 and nothing changes for 1000 cycles.
- `step_div`=3, `enable`=1, `brightness`=255 → a tick every 4 cycles; `green_duty` reaches 4 two cycles after the 4th tick; R stays 255.
- `hue_load` with `hue_value`=0x5FF, then one tick → `wrap` high for exactly one cycle, `sector`=0, outputs R=255, G=0, B=0.
- `hue_load` with `hue_value`=0x280 and `brightness`=127 → R=0, G=127, B=64.
- Mid-sweep with `step_div`=0, assert `reset` between clock edges → all duty outputs and `wrap` go to 0 before the next edge; the sweep restarts from hue 0.
- With `RGB_SWEEP_BREATHE_EN`, `step_div`=0, `brightness`=255 → `env` peaks at 255 after 255 ticks, then descends; at `env`=0 the scale is raw>>8, so R = 0.
